// File: rtl/fp32_window_accumulator.sv
//------------------------------------------------------------------------------
// Module   : fp32_window_accumulator
// Purpose  : Sums TERMS FP32 products (one kernel window), truncating, DAZ/FTZ.
//            Optional macro FP32_ACC_BIAS_EN adds a bias port that seeds acc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp32_window_accumulator #(
    parameter int TERMS = 9,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        busy
`ifdef FP32_ACC_BIAS_EN
    ,
    input  logic [31:0] bias
`endif
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_ALIGN = 2'd1,
        S_ADD   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]      r_acc;
    logic [31:0]      r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Aligned operands captured in ALIGN, consumed in ADD
    logic             r_pass;
    logic [31:0]      r_pass_val;
    logic             r_xs;
    logic [7:0]       r_xe;
    logic [23:0]      r_xm;
    logic [23:0]      r_ym;
    logic             r_sub;

    logic [31:0]      w_acc_init;
    logic [CNT_W-1:0] w_cnt_nxt;

`ifdef FP32_ACC_BIAS_EN
    assign w_acc_init = bias;
`else
    assign w_acc_init = 32'h0000_0000;
`endif

    assign w_cnt_nxt = r_cnt + 1'b1;

    // ---------------- ALIGN stage (combinational) ----------------
    logic        w_b_inf, w_b_zero, w_a_zero, w_a_inf, w_b_gt;
    logic        w_b_s;
    logic [7:0]  w_b_e, w_a_e, w_x_e, w_y_e, w_d;
    logic [22:0] w_b_f, w_a_f, w_x_f, w_y_f;
    logic [23:0] w_y_m;

    // Inf/NaN inputs are clamped to the largest finite magnitude
    assign w_b_inf  = (r_b[30:23] == 8'hFF);
    assign w_b_s    = r_b[31];
    assign w_b_e    = w_b_inf ? 8'hFE : r_b[30:23];
    assign w_b_f    = w_b_inf ? 23'h7F_FFFF : r_b[22:0];
    assign w_b_zero = (r_b[30:23] == 8'h00);
    assign w_a_e    = r_acc[30:23];
    assign w_a_f    = r_acc[22:0];
    assign w_a_zero = (w_a_e == 8'h00);
    assign w_a_inf  = (w_a_e == 8'hFF);
    assign w_b_gt   = ({w_b_e, w_b_f} > {w_a_e, w_a_f});
    assign w_x_e    = w_b_gt ? w_b_e : w_a_e;
    assign w_x_f    = w_b_gt ? w_b_f : w_a_f;
    assign w_y_e    = w_b_gt ? w_a_e : w_b_e;
    assign w_y_f    = w_b_gt ? w_a_f : w_b_f;
    assign w_d      = w_x_e - w_y_e;
    assign w_y_m    = (w_d >= 8'd25) ? 24'h0 : ({1'b1, w_y_f} >> w_d);

    // ---------------- ADD stage (combinational) ----------------
    function automatic logic [4:0] f_lzc(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    logic [24:0] w_sum;
    logic [23:0] w_diff;
    logic [4:0]  w_lz;
    logic [22:0] w_norm_f;
    logic [8:0]  w_sub_e;
    logic [31:0] w_res;
    logic        w_ovf;

    assign w_sum    = {1'b0, r_xm} + {1'b0, r_ym};
    assign w_diff   = r_xm - r_ym;
    assign w_lz     = f_lzc(w_diff);
    assign w_norm_f = 23'(w_diff << w_lz);
    assign w_sub_e  = {1'b0, r_xe} - {4'b0, w_lz};

    always_comb begin
        w_res = r_pass_val;
        w_ovf = 1'b0;
        if (!r_pass) begin
            if (!r_sub) begin
                if (w_sum[24]) begin
                    if (r_xe == 8'hFE) begin
                        w_res = {r_xs, 8'hFF, 23'h0};
                        w_ovf = 1'b1;
                    end else begin
                        w_res = {r_xs, r_xe + 8'd1, w_sum[23:1]};
                    end
                end else begin
                    w_res = {r_xs, r_xe, w_sum[22:0]};
                end
            end else if (w_diff == 24'h0 || w_sub_e[8] || w_sub_e == 9'h0) begin
                w_res = 32'h0000_0000;
            end else begin
                w_res = {r_xs, w_sub_e[7:0], w_norm_f};
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT:  if (in_valid) w_state_nxt = S_ALIGN;
            S_ALIGN: w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = (w_cnt_nxt == CNT_W'(TERMS)) ? S_OUT : S_WAIT;
            S_OUT:   if (out_ready) w_state_nxt = S_WAIT;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= w_acc_init;
            r_b        <= 32'h0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_pass     <= 1'b0;
            r_pass_val <= 32'h0;
            r_xs       <= 1'b0;
            r_xe       <= 8'h0;
            r_xm       <= 24'h0;
            r_ym       <= 24'h0;
            r_sub      <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (in_valid) begin
                        r_b   <= in_data;
                        r_err <= r_err | in_invalid | (in_data[30:23] == 8'hFF);
                    end
                end
                S_ALIGN: begin
                    // Saturated acc ignores further terms; zero operands pass the other through
                    r_pass     <= w_a_inf | w_b_zero | w_a_zero;
                    r_pass_val <= (w_a_inf || w_b_zero) ? r_acc : {w_b_s, w_b_e, w_b_f};
                    r_xs       <= w_b_gt ? w_b_s : r_acc[31];
                    r_xe       <= w_x_e;
                    r_xm       <= {1'b1, w_x_f};
                    r_ym       <= w_y_m;
                    r_sub      <= w_b_s ^ r_acc[31];
                end
                S_ADD: begin
                    r_acc <= w_res;
                    r_err <= r_err | w_ovf;
                    r_cnt <= w_cnt_nxt;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc <= w_acc_init;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_WAIT);
    assign out_valid   = (r_state == S_OUT);
    assign out_data    = out_valid ? r_acc : 32'h0;
    assign out_invalid = out_valid & r_err;
    assign busy        = (r_state != S_WAIT) || (r_cnt != '0);

endmodule

`default_nettype wire

// File: doc/fp32_window_accumulator.md
Name: fp32_window_accumulator

Overview:
- Sequential FP32 accumulator placed directly downstream of the FP32 multiplier in the convolution datapath.
- Consumes one product per handshake, together with the multiplier's invalid flag.
- Sums TERMS products (one kernel window) and presents the window sum on a valid/ready output.
- Clears itself after each window; number format is the same as the multiplier's (denormals are treated as zero).

Parameters:
- TERMS, 9, number of products summed per output (3x3 kernel); legal range 1..255.
- CNT_W, 8, width of the term counter; must satisfy 2^CNT_W > TERMS.

Ports:
- clk  input  1  rising-edge clock, only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product word present.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  32  FP32 product {sign, exp[7:0], frac[22:0]}.
- in_invalid  input  1  multiplier's invalid flag for this product (NaN/Inf operand).
- out_valid  output  1  window sum available.
- out_ready  input  1  consumer accepts the sum.
- out_data  output  32  FP32 window sum.
- out_invalid  output  1  sticky: some term was invalid, or the accumulation overflowed.
- busy  output  1  high whenever the state is not WAIT or the term count is nonzero.

Behaviour:
- Reset: checked on the clock edge.
  - state=WAIT, acc=+0 (0x00000000), count=0, err=0.
  - out_valid=0, out_data=0, out_invalid=0, in_ready=1, busy=0.
  - Reset mid-window or mid-output discards everything; the held result is lost.
- FSM states: WAIT, ALIGN, ADD, OUT.
  - WAIT: in_ready=1. On in_valid, latch in_data into b, OR in_invalid into err, go to ALIGN.
  - ALIGN: in_ready=0.
    - Order the operands so the larger magnitude (exp, then frac) is X, the other Y.
    - d = eX-eY. Y mantissa {1,frac} is shifted right by d with truncation; if d>=25, Y becomes 0.
    - Go to ADD.
  - ADD: in_ready=0. Update acc, then count+1.
    - If count reaches TERMS, go to OUT; otherwise go to WAIT.
  - OUT: out_valid=1, out_data=acc, out_invalid=err, in_ready=0.
    - On out_ready: acc=+0, count=0, err=0, out_valid drops next cycle, go to WAIT.
    - out_data is held stable while out_valid=1 and out_ready=0.
- Timing: 3 cycles per term, minimum. Last accepted term to out_valid=1 is 2 cycles.
- Zero and special handling:
  - Any operand with exp==0 is treated as zero.
  - Zero + x = x, copied bit-exact (including sign).
  - An input with exp==255 sets err; its value is added as if its exp were 254 with frac forced to all-ones, so arithmetic stays finite.
- Arithmetic, same signs: 25-bit sum.
  - If bit24 is set: shift right 1 (truncate) and exp+1.
  - If exp reaches 255: acc=sign,0xFF,0 (Inf) and err=1. Later terms are ignored; acc stays Inf.
- Arithmetic, different signs: mantissa difference.
  - Zero difference gives +0.
  - Otherwise normalise left by the leading-zero count; exp-=lz.
  - If the result exp<=0: flush to +0.
  - Result sign = sign of X.
- No rounding anywhere; all shifts truncate.
- Simultaneous events:
  - in_valid during ALIGN/ADD/OUT is not accepted (in_ready=0); the upstream source holds.
  - out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro name: FP32_ACC_BIAS_EN.
- When defined:
  - Adds port bias input 32, an FP32 bias.
  - bias is sampled into acc at reset and at each OUT->WAIT transition, instead of +0.
  - The window sum equals bias + sum(products), with the same add rules.
- When undefined:
  - No bias port exists.
  - acc always initialises to +0.

Test Plan:
- TERMS=9, nine products 0x3F800000 (1.0), back-to-back in_valid -> one output 0x41100000 (9.0), out_invalid=0; in_ready low 2 cycles after each accept.
- 0x40200000 (2.5), 0xBF000000 (-0.5), then seven 0x00000000 -> 0x40000000 (2.0).
- 0x3F800000, 0xBF800000, then seven zeros -> 0x00000000 (exact cancellation gives +0); count returns to 0.
- 0x7F7FFFFF twice, then seven zeros -> 0x7F800000, out_invalid=1.
- One term with in_invalid=1, the rest 1.0 -> out_invalid=1; err clears after the handshake, and the next clean window gives out_invalid=0.
- Two checks in one scenario:
  - Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout.
  - Assert rst after the 5th term of the next window -> all outputs return to reset values next cycle; the following window sums from +0.
